// File: rtl/rx_downsampler.sv
// Receive-side decimator: picks one of OS samples per symbol, slices the sign and can auto-select
// the sampling phase as the one with the largest accumulated |x| over a 2^LOG2_WIN symbol window.
module rx_downsampler #(
  parameter int unsigned NBT_IN   = 8,
  parameter int unsigned NBF_IN   = 7,
  parameter int unsigned OS       = 4,
  parameter int unsigned LOG2_WIN = 10,
  localparam int unsigned PW      = (OS > 1) ? $clog2(OS) : 1
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_en,
  input  logic [NBT_IN-1:0] i_is_data,
  input  logic              i_auto,
  input  logic [PW-1:0]     i_phase_man,
  output logic [NBT_IN-1:0] o_sample,
  output logic              o_sym,
  output logic              o_valid,
  output logic [PW-1:0]     o_phase,
  output logic              o_phase_upd
);

  localparam int unsigned MW = NBT_IN - 1;
  localparam int unsigned AW = MW + LOG2_WIN;
  localparam logic [PW-1:0] LastPhase = PW'(OS - 1);
  localparam logic [LOG2_WIN-1:0] LastSym = '1;

  if (OS < 2 || NBF_IN >= NBT_IN) begin : g_param_err
    $error("rx_downsampler: OS must be >= 2 and NBF_IN < NBT_IN");
  end

  logic [PW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       phase_q, phase_d;
  logic [LOG2_WIN-1:0] sym_cnt_q, sym_cnt_d;
  logic                eval_q, eval_d;
  logic [AW-1:0]       acc_q [OS];
  logic [AW-1:0]       acc_d [OS];
  logic [NBT_IN-1:0]   sample_q, sample_d;
  logic                sym_q, sym_d;
  logic                valid_q, valid_d;
  logic                upd_q, upd_d;

  logic [PW-1:0]       phase_man;
  logic [PW-1:0]       phase_sel;
  logic [PW-1:0]       best;
  logic [AW-1:0]       best_val;
  logic [NBT_IN-1:0]   neg;
  logic [MW-1:0]       mag;

  // Widened compare so the clamp stays meaningful when OS is not a power of two.
  assign phase_man = ({1'b0, i_phase_man} > {1'b0, LastPhase}) ? LastPhase : i_phase_man;
  assign phase_sel = i_auto ? phase_q : phase_man;
  assign o_phase   = phase_sel;

  // Most-negative input has no positive counterpart; saturate it to the largest magnitude.
  always_comb begin
    neg = '0 - i_is_data;
    mag = i_is_data[MW-1:0];
    if (i_is_data[NBT_IN-1]) begin
      mag = (i_is_data[MW-1:0] == '0) ? '1 : neg[MW-1:0];
    end
  end

  // Strict greater-than keeps ties on the lowest index.
  always_comb begin
    best     = '0;
    best_val = acc_q[0];
    for (int unsigned i = 1; i < OS; i++) begin
      if (acc_q[i] > best_val) begin
        best_val = acc_q[i];
        best     = PW'(i);
      end
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    sym_cnt_d = sym_cnt_q;
    eval_d    = eval_q;
    phase_d   = phase_q;
    acc_d     = acc_q;
    sample_d  = sample_q;
    sym_d     = sym_q;
    valid_d   = 1'b0;
    upd_d     = 1'b0;
    if (i_en) begin
      cnt_d = (cnt_q == LastPhase) ? '0 : cnt_q + PW'(1);
      if (cnt_q == LastPhase) begin
        sym_cnt_d = sym_cnt_q + LOG2_WIN'(1);
        if (sym_cnt_q == LastSym) begin
          eval_d = 1'b1;
        end
      end
      if (cnt_q == phase_sel) begin
        sample_d = i_is_data;
        sym_d    = i_is_data[NBT_IN-1];
        valid_d  = 1'b1;
      end
      // eval_q is only ever pending on the first sample of a new window (cnt_q == 0).
      if (eval_q) begin
        eval_d  = 1'b0;
        phase_d = best;
        upd_d   = 1'b1;
        for (int unsigned i = 0; i < OS; i++) begin
          acc_d[i] = '0;
        end
        acc_d[0] = AW'(mag);
      end else begin
        for (int unsigned i = 0; i < OS; i++) begin
          if (PW'(i) == cnt_q) begin
            acc_d[i] = acc_q[i] + AW'(mag);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      cnt_q     <= '0;
      sym_cnt_q <= '0;
      eval_q    <= 1'b0;
      phase_q   <= '0;
      for (int unsigned i = 0; i < OS; i++) begin
        acc_q[i] <= '0;
      end
      sample_q  <= '0;
      sym_q     <= 1'b0;
      valid_q   <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sym_cnt_q <= sym_cnt_d;
      eval_q    <= eval_d;
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      sym_q     <= sym_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
    end
  end

  assign o_sample    = sample_q;
  assign o_sym       = sym_q;
  assign o_valid     = valid_q;
  assign o_phase_upd = upd_q;

endmodule
